display_scheduler: RTL and testbench
====================================

# display_scheduler

Arbiter and sequencer for the 4-digit seven-segment display. It shares the single 16-bit glyph word consumed by the display renderer between three requesters: alert, message and score. It enforces a minimum on-screen hold time per grant and optionally blinks the granted word. It sits directly upstream of the renderer and drives its `graphics` input.

## Interface
Parameters:
- `HOLD_CYCLES`, default 100_000_000: minimum cycles a granted source stays on screen. Must be ≥ 2.
- `BLINK_CYCLES`, default 25_000_000: length of each blink half-period in cycles. Must be ≥ 1.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req`, in, 3: display request per source. Bit 0 has the highest priority (alert), bit 2 the lowest (score).
- `blink`, in, 3: per-source blink enable, sampled live while that source is granted.
- `gfx0` / `gfx1` / `gfx2`, in, 16 each: glyph words, four 4-bit glyph codes each; `[3:0]` is the rightmost digit.
- `graphics`, out, 16: registered glyph word to the renderer.
- `grant`, out, 3: registered, one-hot or zero; the source currently on screen.
- `start`, out, 1: registered one-cycle pulse in the first cycle of every new grant.

## Operation
- Reset (asynchronous) forces `graphics`=16'hFFFF (all digits off), `grant`=0, `start`=0, state IDLE, and clears both counters.
- States: IDLE, SHOW_MIN, SHOW_OPEN.
- Winner = lowest-index set bit of `req`.
- IDLE:
  - If `req` is nonzero: register `grant`=winner and `start`=1, load the hold counter with HOLD_CYCLES-1, reset the blink phase to ON and its counter to BLINK_CYCLES-1, then go to SHOW_MIN.
  - Otherwise hold `graphics` at 16'hFFFF.
- SHOW_MIN:
  - Decrement the hold counter each cycle.
  - Ignore `req` entirely: neither a request drop nor a higher-priority request changes the grant.
  - When the counter equals 0, go to SHOW_OPEN on the next edge.
- SHOW_OPEN: re-arbitrate every cycle.
  - No request pending: go to IDLE, with `grant`=0 and `graphics`=16'hFFFF.
  - Winner equals the current grant: stay in SHOW_OPEN.
  - Winner differs: switch to the winner with the same actions as the IDLE grant, then go to SHOW_MIN.
- Display word while granted: the selected `gfxN` is tracked live and registered every cycle. When `blink[N]`=1 and the phase is OFF, the word is 16'hFFFF instead.
- Blink counter: decrements in SHOW_* states. At 0 it reloads BLINK_CYCLES-1 and toggles the phase. The counter runs even when `blink[N]`=0, so asserting blink mid-grant follows the running phase.
- `start` is high for exactly one cycle per grant transition. It is 0 when a grant is simply retained in SHOW_OPEN.
- Counter widths are `$clog2` of their parameter. There is no wrap beyond reload.

## Timing
- All outputs are registered. A request first seen at edge E in IDLE produces `grant`, `start` and `graphics` valid after E. Latency is one edge.
- A grant beginning at cycle G holds through cycles G..G+HOLD_CYCLES-1. The earliest change (switch or release) is visible at G+HOLD_CYCLES.
- In SHOW_OPEN, a new higher-priority request changes the grant one edge after it is sampled.
- Blink with the grant at G: ON for G..G+BLINK_CYCLES-1, OFF for the next BLINK_CYCLES cycles, and so on.
- Simultaneous requests resolve by fixed priority; 3'b111 grants bit 0.
- Reset mid-grant blanks the display immediately (asynchronously). After release, the block is in IDLE and grants on the first sampled request.

## Structure
- Package `display_pkg`:
  - glyph constants GLYPH_A=4'hA, GLYPH_R=4'hB, GLYPH_G=4'hC, GLYPH_E=4'hD, GLYPH_EQ=4'hE, GLYPH_OFF=4'hF;
  - BLANK_WORD=16'hFFFF;
  - the state enum `sched_state_t`.
- One sub-module, `priority_pick`: 3-bit fixed-priority one-hot selector, combinational, reused for winner selection.

## Test plan
Run with HOLD_CYCLES=4 and BLINK_CYCLES=2.
- Idle grant: set `req`=3'b100 and `gfx2`=16'h1234. After one edge, `grant`=3'b100, `start`=1 for exactly one cycle, and `graphics`=16'h1234.
- Hold versus preemption: source 2 is granted at G and `req[0]` rises at G+1. `grant` stays 3'b100 through G+3. At G+4, `grant`=3'b001 and `start`=1.
- Simultaneous requests: `req`=3'b111 from IDLE grants 3'b001. With `req` held, `grant` stays 3'b001 forever with no further `start` pulses.
- Blink: `blink[0]`=1 and `gfx0`=16'hDBBF. `graphics` reads DBBF, DBBF, FFFF, FFFF, DBBF, and so on from G.
- Release during hold: drop `req` at G+1. `graphics` keeps the source word through G+3. At G+4, `grant`=0 and `graphics`=16'hFFFF.
- Reset mid-grant: pulse `rst` asynchronously between edges. `graphics`=16'hFFFF and `grant`=0 immediately. After release, the next request is granted with `start`=1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and state encoding for the seven-segment display scheduler.
package display_pkg;

  localparam logic [3:0] GLYPH_A   = 4'hA;
  localparam logic [3:0] GLYPH_R   = 4'hB;
  localparam logic [3:0] GLYPH_G   = 4'hC;
  localparam logic [3:0] GLYPH_E   = 4'hD;
  localparam logic [3:0] GLYPH_EQ  = 4'hE;
  localparam logic [3:0] GLYPH_OFF = 4'hF;

  localparam logic [15:0] BLANK_WORD = {4{GLYPH_OFF}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHOW_MIN  = 2'd1,
    SHOW_OPEN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/priority_pick.sv
// 3-bit fixed-priority one-hot selector; bit 0 wins. Purely combinational.
module priority_pick (
  input  logic [2:0] req,
  output logic [2:0] pick
);

  always_comb begin
    pick = 3'b000;
    if (req[0])      pick = 3'b001;
    else if (req[1]) pick = 3'b010;
    else if (req[2]) pick = 3'b100;
  end

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates the display glyph word between alert/message/score with a minimum hold and blink.
// All outputs registered; a request seen in IDLE is on screen one edge later.
module display_scheduler
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES  = 100_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  blink,
  input  logic [15:0] gfx0,
  input  logic [15:0] gfx1,
  input  logic [15:0] gfx2,
  output logic [15:0] graphics,
  output logic [2:0]  grant,
  output logic        start
);

  localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);

  sched_state_t  state, nxt_state;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [BW-1:0] blink_cnt, blink_nxt;
  logic          phase_on, phase_nxt;
  logic [2:0]    win, grant_nxt;
  logic          load;
  logic [15:0]   word_sel, graphics_nxt;
  logic          blink_sel;

  priority_pick u_pick (
    .req  (req),
    .pick (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
      grant     <= 3'b000;
      start     <= 1'b0;
      graphics  <= BLANK_WORD;
    end else begin
      state     <= nxt_state;
      hold_cnt  <= hold_nxt;
      blink_cnt <= blink_nxt;
      phase_on  <= phase_nxt;
      grant     <= grant_nxt;
      start     <= load;
      graphics  <= graphics_nxt;
    end
  end

  // The last SHOW_MIN cycle arbitrates like SHOW_OPEN, so the earliest
  // change lands exactly HOLD_CYCLES after the grant began.
  always_comb begin
    nxt_state = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (req != 3'b000) begin
          nxt_state = SHOW_MIN;
          load      = 1'b1;
        end
      end
      SHOW_MIN, SHOW_OPEN: begin
        if (state == SHOW_OPEN || hold_cnt == '0) begin
          if (req == 3'b000) begin
            nxt_state = IDLE;
          end else if (win != grant) begin
            nxt_state = SHOW_MIN;
            load      = 1'b1;
          end else begin
            nxt_state = SHOW_OPEN;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    grant_nxt = grant;
    hold_nxt  = hold_cnt;
    blink_nxt = blink_cnt;
    phase_nxt = phase_on;
    if (load) begin
      grant_nxt = win;
      hold_nxt  = HOLD_LOAD;
      blink_nxt = BLINK_LOAD;
      phase_nxt = 1'b1;
    end else begin
      if (nxt_state == IDLE) grant_nxt = 3'b000;
      if (state == SHOW_MIN && hold_cnt != '0) hold_nxt = hold_cnt - HW'(1);
      if (state != IDLE) begin
        if (blink_cnt == '0) begin
          blink_nxt = BLINK_LOAD;
          phase_nxt = ~phase_on;
        end else begin
          blink_nxt = blink_cnt - BW'(1);
        end
      end
    end
  end

  // The word and blink enable follow the next grant so graphics lines up with it.
  always_comb begin
    word_sel  = BLANK_WORD;
    blink_sel = 1'b0;
    case (grant_nxt)
      3'b001:  begin word_sel = gfx0; blink_sel = blink[0]; end
      3'b010:  begin word_sel = gfx1; blink_sel = blink[1]; end
      3'b100:  begin word_sel = gfx2; blink_sel = blink[2]; end
      default: begin word_sel = BLANK_WORD; blink_sel = 1'b0; end
    endcase
    graphics_nxt = (blink_sel && !phase_nxt) ? BLANK_WORD : word_sel;
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized and directed bench for display_scheduler against a cycle-arithmetic reference model.
module tb_display_scheduler;

  localparam int H = 4;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, blink;
  logic [15:0] gfx0, gfx1, gfx2;
  logic [15:0] graphics;
  logic [2:0]  grant;
  logic        start;

  int checks = 0;
  int errors = 0;

  // reference model: current grant, cycle it began, current cycle number
  logic [2:0]  m_grant;
  logic        m_start;
  logic [15:0] m_gfx;
  int          m_g;
  int          t;

  display_scheduler #(.HOLD_CYCLES(H), .BLINK_CYCLES(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .blink    (blink),
    .gfx0     (gfx0),
    .gfx1     (gfx1),
    .gfx2     (gfx2),
    .graphics (graphics),
    .grant    (grant),
    .start    (start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", tag, got, exp, t);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [2:0] r);
    logic [2:0] o;
    o = 3'b000;
    for (int i = 2; i >= 0; i--) if (r[i]) o = 3'b001 << i;
    return o;
  endfunction

  task automatic model_reset();
    m_grant = 3'b000;
    m_start = 1'b0;
    m_gfx   = 16'hFFFF;
    m_g     = 0;
  endtask

  task automatic model_edge();
    logic [2:0]  w;
    logic [15:0] word;
    logic        b;
    t++;
    w = lowest(req);
    m_start = 1'b0;
    if (m_grant == 3'b000) begin
      if (req != 3'b000) begin m_grant = w; m_g = t; m_start = 1'b1; end
    end else if (t - m_g >= H) begin
      if (req == 3'b000) m_grant = 3'b000;
      else if (w != m_grant) begin m_grant = w; m_g = t; m_start = 1'b1; end
    end
    word = 16'hFFFF;
    b    = 1'b0;
    if (m_grant == 3'b001) begin word = gfx0; b = blink[0]; end
    if (m_grant == 3'b010) begin word = gfx1; b = blink[1]; end
    if (m_grant == 3'b100) begin word = gfx2; b = blink[2]; end
    if (m_grant == 3'b000 || (b && (((t - m_g) / B) % 2 == 1))) m_gfx = 16'hFFFF;
    else m_gfx = word;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("grant", 16'(grant), 16'(m_grant));
    check("start", 16'(start), 16'(m_start));
    check("graphics", graphics, m_gfx);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_graphics", graphics, 16'hFFFF);
    check("rst_grant", 16'(grant), 16'h0000);
    check("rst_start", 16'(start), 16'h0000);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    t = 0;
    rst = 1'b1;
    req = 3'b000; blink = 3'b000;
    gfx0 = 16'h0000; gfx1 = 16'h1111; gfx2 = 16'h2222;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_graphics", graphics, 16'hFFFF);
    check("reset_grant", 16'(grant), 16'h0000);
    check("reset_start", 16'(start), 16'h0000);
    rst = 1'b0;
    step();
    check("idle_blank", graphics, 16'hFFFF);

    // idle grant of source 2, then preemption by source 0 after the hold
    req = 3'b100; gfx2 = 16'h1234;
    step();
    check("idle_grant", 16'(grant), 16'h0004);
    check("idle_start", 16'(start), 16'h0001);
    check("idle_word", graphics, 16'h1234);
    req = 3'b101; gfx0 = 16'hDBBF;
    for (int i = 1; i < H; i++) begin
      step();
      check("hold_grant", 16'(grant), 16'h0004);
      check("hold_nostart", 16'(start), 16'h0000);
    end
    step();
    check("preempt_grant", 16'(grant), 16'h0001);
    check("preempt_start", 16'(start), 16'h0001);

    // release during hold
    req = 3'b000;
    for (int i = 1; i < H; i++) begin
      step();
      check("rel_hold_grant", 16'(grant), 16'h0001);
      check("rel_hold_word", graphics, 16'hDBBF);
    end
    step();
    check("rel_grant", 16'(grant), 16'h0000);
    check("rel_word", graphics, 16'hFFFF);

    // blink: ON for B cycles, OFF for B, from the grant cycle
    blink = 3'b001; req = 3'b001;
    for (int i = 0; i < 5; i++) begin
      step();
      check("blink_word", graphics, (((i / B) % 2) == 1) ? 16'hFFFF : 16'hDBBF);
    end
    req = 3'b000; blink = 3'b000;
    repeat (6) step();

    // simultaneous requests resolve to bit 0 and are retained without start
    req = 3'b111;
    step();
    check("all_grant", 16'(grant), 16'h0001);
    check("all_start", 16'(start), 16'h0001);
    repeat (8) begin
      step();
      check("all_keep", 16'(grant), 16'h0001);
      check("all_nostart", 16'(start), 16'h0000);
    end

    // asynchronous reset mid-grant
    pulse_reset();
    req = 3'b010; gfx1 = 16'hABCD;
    step();
    check("post_rst_grant", 16'(grant), 16'h0002);
    check("post_rst_start", 16'(start), 16'h0001);
    check("post_rst_word", graphics, 16'hABCD);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) req = 3'($urandom);
      if ($urandom_range(7) == 0) blink = 3'($urandom);
      if ($urandom_range(5) == 0) gfx0 = 16'($urandom);
      if ($urandom_range(5) == 0) gfx1 = 16'($urandom);
      if ($urandom_range(5) == 0) gfx2 = 16'($urandom);
      if ($urandom_range(499) == 0) pulse_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
